// File: rtl/dataframe_arb_pkg.sv
// Shared definitions for the dataframe stream arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, LOCKED, CLOSE)
//   - TERM_*      : bit values used to build the stall terminator beat
//   - idx_width() : width of an index able to address n items (minimum 1)
// RFDC_TDATA_WIDTH supplies the default beat width when the build does not.

`ifndef RFDC_TDATA_WIDTH
`define RFDC_TDATA_WIDTH 128
`endif

package dataframe_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_CLOSE  = 2'd2
    } arb_state_e;

    // Terminator beat: every TDATA bit set, no valid bytes, TLAST asserted.
    localparam logic TERM_DATA_BIT = 1'b1;
    localparam logic TERM_KEEP_BIT = 1'b0;
    localparam logic TERM_LAST     = 1'b1;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dataframe_stream_arbiter_if.sv
// Bundle of the N per-source AXI4-Stream inputs and the merged AXI4-Stream
// output of the dataframe stream arbiter.
//   s_tvalid/s_tready/s_tlast : one bit per source
//   s_tdata/s_tkeep           : source i at [i*W +: W] / [i*W/8 +: W/8]
//   m_*                       : merged stream, m_tdest = source index
// Modports: master = arbiter side, slave = sources plus downstream sink.

interface dataframe_stream_arbiter_if
    import dataframe_arb_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int TDATA_WIDTH = `RFDC_TDATA_WIDTH
);
    localparam int DEST_W = idx_width(N_CH);

    logic [N_CH-1:0]               s_tvalid;
    logic [N_CH-1:0]               s_tready;
    logic [N_CH*TDATA_WIDTH-1:0]   s_tdata;
    logic [N_CH*TDATA_WIDTH/8-1:0] s_tkeep;
    logic [N_CH-1:0]               s_tlast;

    logic                          m_tready;
    logic                          m_tvalid;
    logic [TDATA_WIDTH-1:0]        m_tdata;
    logic [TDATA_WIDTH/8-1:0]      m_tkeep;
    logic                          m_tlast;
    logic [DEST_W-1:0]             m_tdest;

    modport master (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest
    );

    modport slave (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest
    );

endinterface

// File: rtl/rr_frame_picker.sv
// Combinational rotate-priority selector. Searches req starting at
// last_grant+1 and wrapping, returns the first requester found.
//   req        in  N_CH   requesting sources
//   last_grant in  IW     source granted most recently
//   grant      out IW     selected source (0 when none)
//   any        out 1      at least one requester present

module rr_frame_picker
    import dataframe_arb_pkg::*;
#(
    parameter int  N_CH = 8,
    localparam int IW   = idx_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   grant,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would infer a latch.
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N_CH; off++) begin
            cand = IW'((int'(last_grant) + off) % N_CH);
            if (!any && req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/dataframe_stream_arbiter.sv
// Frame-granular round-robin merge of N_CH AXI4-Stream sources into one
// registered output stream. A grant lasts from the first beat of a frame
// to its accepted TLAST beat. A watchdog closes a frame whose source keeps
// TVALID low for STALL_LIMIT cycles by emitting a terminator beat and then
// discarding that source's remaining beats up to its TLAST.
//   ACLK, ARESET : clock, asynchronous active-high reset
//   bus          : per-source inputs and merged output (master modport)
//   ARB_ERROR    : sticky, set on the first watchdog expiry
//   ERROR_CH     : source index of the first watchdog expiry

module dataframe_stream_arbiter
    import dataframe_arb_pkg::*;
#(
    parameter int  N_CH        = 8,
    parameter int  TDATA_WIDTH = `RFDC_TDATA_WIDTH,
    parameter int  STALL_LIMIT = 1024,
    localparam int IW          = idx_width(N_CH)
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    dataframe_stream_arbiter_if.master      bus,
    output logic                            ARB_ERROR,
    output logic [IW-1:0]                   ERROR_CH
);

    localparam int KW = TDATA_WIDTH / 8;
    localparam int SW = idx_width(STALL_LIMIT);

    arb_state_e             state;
    logic [IW-1:0]          grant;
    logic [IW-1:0]          last_grant;
    logic [N_CH-1:0]        flush;
    logic [SW-1:0]          stall_cnt;
    logic                   arb_error;
    logic [IW-1:0]          error_ch;

    logic                   out_valid;
    logic [TDATA_WIDTH-1:0] out_data;
    logic [KW-1:0]          out_keep;
    logic                   out_last;
    logic [IW-1:0]          out_dest;

    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        src_ready;
    logic [N_CH-1:0]        flush_done;
    logic [IW-1:0]          pick_grant;
    logic                   pick_any;
    logic                   out_free;
    logic                   beat_accept;
    logic                   stall_expired;
    logic [TDATA_WIDTH-1:0] beat_data;
    logic [KW-1:0]          beat_keep;

    // Sources still draining a closed frame must not win a new grant.
    assign req = bus.s_tvalid & ~flush;

    rr_frame_picker #(.N_CH(N_CH)) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = ~out_valid | bus.m_tready;

    // Flushing sources are always ready so their leftover beats are dropped.
    always_comb begin
        src_ready = flush;
        if (state == ST_LOCKED && out_free) begin
            src_ready[grant] = 1'b1;
        end
    end

    assign bus.s_tready  = src_ready;
    assign beat_accept   = (state == ST_LOCKED) && bus.s_tvalid[grant] && out_free;
    assign beat_data     = bus.s_tdata[grant*TDATA_WIDTH +: TDATA_WIDTH];
    assign beat_keep     = bus.s_tkeep[grant*KW +: KW];
    assign flush_done    = flush & bus.s_tvalid & bus.s_tlast;
    assign stall_expired = (stall_cnt == SW'(STALL_LIMIT - 1));

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IW'(N_CH - 1);
            flush      <= '0;
            stall_cnt  <= '0;
            arb_error  <= 1'b0;
            error_ch   <= '0;
            out_valid  <= 1'b0;
            out_data   <= {TDATA_WIDTH{TERM_DATA_BIT}};
            out_keep   <= {KW{TERM_KEEP_BIT}};
            out_last   <= 1'b0;
            out_dest   <= '0;
        end else begin
            flush <= flush & ~flush_done;

            if (out_valid && bus.m_tready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (pick_any) begin
                        grant <= pick_grant;
                        state <= ST_LOCKED;
                    end
                end

                ST_LOCKED: begin
                    if (beat_accept) begin
                        // An accepted beat always beats a watchdog expiry.
                        out_valid <= 1'b1;
                        out_data  <= beat_data;
                        out_keep  <= beat_keep;
                        out_last  <= bus.s_tlast[grant];
                        out_dest  <= grant;
                        stall_cnt <= '0;
                        if (bus.s_tlast[grant]) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end else if (!bus.s_tvalid[grant]) begin
                        if (stall_expired) begin
                            flush[grant] <= 1'b1;
                            state        <= ST_CLOSE;
                            if (!arb_error) begin
                                arb_error <= 1'b1;
                                error_ch  <= grant;
                            end
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end

                ST_CLOSE: begin
                    if (out_free) begin
                        out_valid  <= 1'b1;
                        out_data   <= {TDATA_WIDTH{TERM_DATA_BIT}};
                        out_keep   <= {KW{TERM_KEEP_BIT}};
                        out_last   <= TERM_LAST;
                        out_dest   <= grant;
                        last_grant <= grant;
                        stall_cnt  <= '0;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_tvalid = out_valid;
    assign bus.m_tdata  = out_data;
    assign bus.m_tkeep  = out_keep;
    assign bus.m_tlast  = out_last;
    assign bus.m_tdest  = out_dest;
    assign ARB_ERROR    = arb_error;
    assign ERROR_CH     = error_ch;

endmodule

// File: tb/tb_dataframe_stream_arbiter.sv
// Directed self-checking bench for dataframe_stream_arbiter: reset values,
// round robin with frame bubbles, backpressure hold, fairness, watchdog
// stall/flush and asynchronous reset mid-frame.

module tb_dataframe_stream_arbiter;
    import dataframe_arb_pkg::*;

    localparam int N_CH        = 8;
    localparam int W           = 32;
    localparam int KW          = W / 8;
    localparam int STALL_LIMIT = 16;
    localparam int IW          = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic          arb_error;
    logic [IW-1:0] error_ch;

    dataframe_stream_arbiter_if #(.N_CH(N_CH), .TDATA_WIDTH(W)) bus ();

    dataframe_stream_arbiter #(
        .N_CH        (N_CH),
        .TDATA_WIDTH (W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .ACLK      (aclk),
        .ARESET    (areset),
        .bus       (bus),
        .ARB_ERROR (arb_error),
        .ERROR_CH  (error_ch)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source model: each source plays src_left frames of src_len beats and
    // optionally drops TVALID while sitting on beat src_stall_at.
    int src_len      [N_CH];
    int src_pos      [N_CH];
    int src_left     [N_CH];
    int src_frame    [N_CH];
    int src_stall_at [N_CH];
    bit src_stall    [N_CH];

    logic [N_CH-1:0] s_acc;
    bit              ready_toggle;
    bit              held;
    logic [39:0]     held_beat;

    logic [W-1:0]  log_data [$];
    logic [KW-1:0] log_keep [$];
    logic          log_last [$];
    logic [IW-1:0] log_dest [$];
    int            log_cyc  [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N_CH; i++) begin
            bus.s_tvalid[i]            = (src_left[i] > 0) && !(src_stall[i] && src_pos[i] == src_stall_at[i]);
            bus.s_tdata[i*W +: W]      = {8'(i), 8'(src_frame[i]), 16'(src_pos[i])};
            bus.s_tkeep[i*KW +: KW]    = '1;
            bus.s_tlast[i]             = (src_pos[i] == src_len[i] - 1);
        end
    endtask

    task automatic load_src(input int i, input int len, input int frames);
        src_len[i]   = len;
        src_pos[i]   = 0;
        src_left[i]  = frames;
        src_frame[i] = 0;
        src_stall[i] = 1'b0;
        drive_sources();
    endtask

    task automatic clear_log();
        log_data.delete();
        log_keep.delete();
        log_last.delete();
        log_dest.delete();
        log_cyc.delete();
    endtask

    // One clock: sample handshakes at the negedge, advance the model after
    // the posedge.
    task automatic tick();
        @(negedge aclk);
        cyc++;
        s_acc = bus.s_tvalid & bus.s_tready;
        if (held) begin
            check("hold_valid", 64'(bus.m_tvalid), 64'd1);
            check("hold_beat", 64'({bus.m_tlast, bus.m_tdest, bus.m_tkeep, bus.m_tdata}), 64'(held_beat));
        end
        held      = bus.m_tvalid && !bus.m_tready;
        held_beat = {bus.m_tlast, bus.m_tdest, bus.m_tkeep, bus.m_tdata};
        if (bus.m_tvalid && bus.m_tready) begin
            log_data.push_back(bus.m_tdata);
            log_keep.push_back(bus.m_tkeep);
            log_last.push_back(bus.m_tlast);
            log_dest.push_back(bus.m_tdest);
            log_cyc.push_back(cyc);
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (s_acc[i]) begin
                if (src_pos[i] == src_len[i] - 1) begin
                    src_pos[i] = 0;
                    src_frame[i]++;
                    src_left[i]--;
                end else begin
                    src_pos[i]++;
                end
            end
        end
        if (ready_toggle) bus.m_tready = ~bus.m_tready;
        drive_sources();
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(log_data.size()), 64'(n));
    endtask

    initial begin
        int fd [4] = '{5, 0, 5, 0};
        int ff [4] = '{0, 0, 1, 1};

        areset       = 1'b1;
        bus.m_tready = 1'b0;
        ready_toggle = 1'b0;
        held         = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            src_len[i] = 1; src_pos[i] = 0; src_left[i] = 0;
            src_frame[i] = 0; src_stall_at[i] = 0; src_stall[i] = 1'b0;
        end
        drive_sources();

        // Reset values
        #1;
        check("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst_tdata", 64'(bus.m_tdata), 64'hFFFF_FFFF);
        check("rst_tkeep", 64'(bus.m_tkeep), 64'd0);
        check("rst_tlast", 64'(bus.m_tlast), 64'd0);
        check("rst_tdest", 64'(bus.m_tdest), 64'd0);
        check("rst_s_tready", 64'(bus.s_tready), 64'd0);
        check("rst_arb_error", 64'(arb_error), 64'd0);
        check("rst_error_ch", 64'(error_ch), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        tick();
        tick();
        check("idle_s_tready", 64'(bus.s_tready), 64'd0);
        check("idle_tvalid", 64'(bus.m_tvalid), 64'd0);

        // Round robin: sources 0,1,2 with one 4-beat frame each
        bus.m_tready = 1'b1;
        clear_log();
        load_src(0, 4, 1);
        load_src(1, 4, 1);
        load_src(2, 4, 1);
        run_until("rr_count", 12, 80);
        for (int k = 0; k < 12 && k < log_data.size(); k++) begin
            check($sformatf("rr_dest%0d", k), 64'(log_dest[k]), 64'(k / 4));
            check($sformatf("rr_data%0d", k), 64'(log_data[k]), 64'({8'(k / 4), 8'h00, 16'(k % 4)}));
            check($sformatf("rr_last%0d", k), 64'(log_last[k]), 64'(k % 4 == 3));
        end
        if (log_cyc.size() >= 12) begin
            check("rr_in_frame_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
            check("rr_bubble_1", 64'(log_cyc[4] - log_cyc[3]), 64'd2);
            check("rr_bubble_2", 64'(log_cyc[8] - log_cyc[7]), 64'd2);
        end

        // Backpressure: 6-beat frame on source 3, TREADY toggling
        clear_log();
        ready_toggle = 1'b1;
        load_src(3, 6, 1);
        run_until("bp_count", 6, 60);
        repeat (6) tick();
        check("bp_no_dup", 64'(log_data.size()), 64'd6);
        ready_toggle = 1'b0;
        bus.m_tready = 1'b1;
        for (int k = 0; k < 6 && k < log_data.size(); k++) begin
            check($sformatf("bp_dest%0d", k), 64'(log_dest[k]), 64'd3);
            check($sformatf("bp_data%0d", k), 64'(log_data[k]), 64'({8'h03, 8'h00, 16'(k)}));
            check($sformatf("bp_last%0d", k), 64'(log_last[k]), 64'(k == 5));
        end

        // Fairness: sources 0 and 5 each with two 2-beat frames
        clear_log();
        load_src(0, 2, 2);
        load_src(5, 2, 2);
        run_until("fair_count", 8, 60);
        for (int k = 0; k < 8 && k < log_data.size(); k++) begin
            check($sformatf("fair_dest%0d", k), 64'(log_dest[k]), 64'(fd[k / 2]));
            check($sformatf("fair_data%0d", k), 64'(log_data[k]), 64'({8'(fd[k / 2]), 8'(ff[k / 2]), 16'(k % 2)}));
        end

        // Stall: source 2 sends 2 of 5 beats then drops TVALID
        clear_log();
        load_src(2, 5, 1);
        src_stall_at[2] = 2;
        src_stall[2]    = 1'b1;
        drive_sources();
        run_until("stall_head", 2, 20);
        repeat (8) tick();
        check("stall_below_err", 64'(arb_error), 64'd0);
        check("stall_below_beats", 64'(log_data.size()), 64'd2);
        run_until("stall_term", 3, 40);
        if (log_data.size() >= 3) begin
            check("stall_beat0", 64'({log_last[0], log_dest[0], log_data[0]}), 64'({1'b0, 3'd2, 8'h02, 8'h00, 16'h0000}));
            check("stall_beat1", 64'({log_last[1], log_dest[1], log_data[1]}), 64'({1'b0, 3'd2, 8'h02, 8'h00, 16'h0001}));
            check("term_tdata", 64'(log_data[2]), 64'hFFFF_FFFF);
            check("term_tkeep", 64'(log_keep[2]), 64'd0);
            check("term_tlast", 64'(log_last[2]), 64'd1);
            check("term_tdest", 64'(log_dest[2]), 64'd2);
        end
        check("stall_arb_error", 64'(arb_error), 64'd1);
        check("stall_error_ch", 64'(error_ch), 64'd2);
        check("flush_tready", 64'(bus.s_tready[2]), 64'd1);
        clear_log();
        load_src(1, 3, 1);
        src_stall[2] = 1'b0;
        drive_sources();
        run_until("post_stall", 3, 40);
        repeat (4) tick();
        check("post_stall_count", 64'(log_data.size()), 64'd3);
        for (int k = 0; k < 3 && k < log_data.size(); k++) begin
            check($sformatf("post_dest%0d", k), 64'(log_dest[k]), 64'd1);
            check($sformatf("post_data%0d", k), 64'(log_data[k]), 64'({8'h01, 8'h00, 16'(k)}));
            check($sformatf("post_last%0d", k), 64'(log_last[k]), 64'(k == 2));
        end
        check("flush_drained", 64'(src_left[2]), 64'd0);
        check("flush_cleared", 64'(bus.s_tready[2]), 64'd0);
        check("sticky_error_ch", 64'(error_ch), 64'd2);

        // Asynchronous reset while beat 3 of a frame sits on the output
        clear_log();
        load_src(4, 8, 1);
        run_until("ar_head", 2, 20);
        check("ar_pre_tvalid", 64'(bus.m_tvalid), 64'd1);
        #2;
        areset = 1'b1;
        #1;
        check("ar_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("ar_tdata", 64'(bus.m_tdata), 64'hFFFF_FFFF);
        check("ar_tlast", 64'(bus.m_tlast), 64'd0);
        check("ar_tdest", 64'(bus.m_tdest), 64'd0);
        check("ar_s_tready", 64'(bus.s_tready), 64'd0);
        check("ar_arb_error", 64'(arb_error), 64'd0);
        check("ar_error_ch", 64'(error_ch), 64'd0);
        for (int i = 0; i < N_CH; i++) src_left[i] = 0;
        drive_sources();
        held = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        clear_log();
        load_src(0, 1, 1);
        load_src(6, 1, 1);
        run_until("ar_after", 2, 20);
        if (log_data.size() >= 2) begin
            check("ar_first_dest", 64'(log_dest[0]), 64'd0);
            check("ar_first_last", 64'(log_last[0]), 64'd1);
            check("ar_second_dest", 64'(log_dest[1]), 64'd6);
            check("ar_second_data", 64'(log_data[1]), 64'({8'h06, 8'h00, 16'h0000}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
